// File: rtl/tlb_op_ctrl.sv
// Sequencer for the MIPS TLB maintenance ops (TLBP/TLBR/TLBWI) between WB, CP0 and the TLB.
// One op at a time; TLBR/TLBWI finish with a refetch of op_pc+4 because translation changed.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic [31:0]      op_pc,
  output logic             op_ready,
  input  logic             ex_flush,
  input  logic             entryhi_busy,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_index,
  output logic [18:0]      s1_vpn2,
  output logic [7:0]       s1_asid,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             index_we,
  output logic [31:0]      index_wdata,
  output logic [IDX_W-1:0] r_index,
  output logic             tlbr_we,
  output logic             tlb_we,
  output logic [IDX_W-1:0] w_index,
  output logic             refetch_valid,
  output logic [31:0]      refetch_pc,
  input  logic             refetch_ack
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_EHI = 3'd1,
    PROBE    = 3'd2,
    READ     = 3'd3,
    WRITE    = 3'd4,
    REFETCH  = 3'd5
  } state_t;

  state_t      state_r;
  logic        op_ready_r;
  logic        index_we_r;
  logic        tlbr_we_r;
  logic        tlb_we_r;
  logic        refetch_valid_r;
  logic [31:0] refetch_pc_r;
  logic [31:0] op_pc_r;
  logic [1:0]  op_type_r;
  logic        unused_bits;

  assign s1_vpn2     = cp0_entryhi[31:13];
  assign s1_asid     = cp0_entryhi[7:0];
  assign index_wdata = {~s1_found, {(31-IDX_W){1'b0}}, s1_index};
  assign r_index     = cp0_index[IDX_W-1:0];
  assign w_index     = cp0_index[IDX_W-1:0];

  // A flush must kill the strobe/refetch of the very cycle it arrives in, hence the gating.
  assign op_ready      = op_ready_r;
  assign index_we      = index_we_r & ~ex_flush;
  assign tlbr_we       = tlbr_we_r & ~ex_flush;
  assign tlb_we        = tlb_we_r & ~ex_flush;
  assign refetch_valid = refetch_valid_r & ~ex_flush;
  assign refetch_pc    = refetch_pc_r;

  assign unused_bits = ^{cp0_entryhi[12:8], cp0_index[31:IDX_W], op_type_r,
                         TLBNUM == (1 << IDX_W)};

  // Op sequencing FSM; strobes are registered so they rise in the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      op_ready_r      <= 1'b1;
      index_we_r      <= 1'b0;
      tlbr_we_r       <= 1'b0;
      tlb_we_r        <= 1'b0;
      refetch_valid_r <= 1'b0;
      refetch_pc_r    <= 32'd0;
      op_pc_r         <= 32'd0;
      op_type_r       <= 2'b00;
    end else begin
      index_we_r <= 1'b0;
      tlbr_we_r  <= 1'b0;
      tlb_we_r   <= 1'b0;
      if (ex_flush && state_r != IDLE) begin
        state_r         <= IDLE;
        op_ready_r      <= 1'b1;
        refetch_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (op_valid && !ex_flush) begin
              op_type_r <= op_type;
              op_pc_r   <= op_pc;
              case (op_type)
                2'b01: begin
                  op_ready_r <= 1'b0;
                  if (entryhi_busy) begin
                    state_r <= WAIT_EHI;
                  end else begin
                    state_r    <= PROBE;
                    index_we_r <= 1'b1;
                  end
                end
                2'b10: begin
                  op_ready_r <= 1'b0;
                  state_r    <= READ;
                  tlbr_we_r  <= 1'b1;
                end
                2'b11: begin
                  op_ready_r <= 1'b0;
                  state_r    <= WRITE;
                  tlb_we_r   <= 1'b1;
                end
                default: state_r <= IDLE;
              endcase
            end
          end
          WAIT_EHI: begin
            if (!entryhi_busy) begin
              state_r    <= PROBE;
              index_we_r <= 1'b1;
            end
          end
          PROBE: begin
            state_r    <= IDLE;
            op_ready_r <= 1'b1;
          end
          READ, WRITE: begin
            state_r         <= REFETCH;
            refetch_valid_r <= 1'b1;
            refetch_pc_r    <= op_pc_r + 32'd4;
          end
          REFETCH: begin
            if (refetch_ack) begin
              state_r         <= IDLE;
              op_ready_r      <= 1'b1;
              refetch_valid_r <= 1'b0;
            end
          end
          default: begin
            state_r         <= IDLE;
            op_ready_r      <= 1'b1;
            refetch_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
